// File: rtl/eee_sobel_stream.sv
`default_nettype none
// ============================================================================
// Module   : eee_sobel_stream
// Purpose  : Streaming 3x3 Sobel edge detector. Avalon-ST in/out, Avalon-MM
//            control/status. Optional macro EEE_EDGE_COUNT_EN adds the
//            per-frame edge-pixel counter behind the EDGES register.
// Revision : 1.0 - initial release
// ============================================================================
module eee_sobel_stream #(
  parameter int PIX_BITS   = 8,
  parameter int CHANNELS   = 3,
  parameter int IMG_WIDTH  = 640,
  parameter int THRESH_RST = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [PIX_BITS*CHANNELS-1:0] sink_data,
  input  logic                         sink_valid,
  output logic                         sink_ready,
  input  logic                         sink_sop,
  input  logic                         sink_eop,
  output logic [PIX_BITS*CHANNELS-1:0] source_data,
  output logic                         source_valid,
  input  logic                         source_ready,
  output logic                         source_sop,
  output logic                         source_eop,
  input  logic                         s_chipselect,
  input  logic                         s_read,
  input  logic                         s_write,
  input  logic [2:0]                   s_address,
  input  logic [31:0]                  s_writedata,
  output logic [31:0]                  s_readdata,
  input  logic                         mode
);

  localparam int c_DW    = PIX_BITS * CHANNELS;
  localparam int c_COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int c_ROW_W = 16;
  localparam int c_GW    = PIX_BITS + 3;
  localparam int c_MW    = c_GW + 1;

  localparam logic [c_COL_W-1:0]  c_COL_LAST   = c_COL_W'(IMG_WIDTH - 1);
  localparam logic [PIX_BITS-1:0] c_PIX_MAX    = '1;
  localparam logic [PIX_BITS-1:0] c_THRESH_RST = PIX_BITS'(THRESH_RST);
  localparam logic [31:0]         c_ID         = 32'h5E0B_0001;

  localparam logic [2:0] c_A_CTRL   = 3'd0;
  localparam logic [2:0] c_A_THRESH = 3'd1;
  localparam logic [2:0] c_A_STATUS = 3'd2;
  localparam logic [2:0] c_A_FRAMES = 3'd3;
  localparam logic [2:0] c_A_EDGES  = 3'd4;
  localparam logic [2:0] c_A_ID     = 3'd5;

  logic                r_rst_done;
  logic                w_advance;
  logic                w_accept;
  logic [PIX_BITS-1:0] w_luma;
  logic [c_COL_W-1:0]  r_col;
  logic [c_COL_W-1:0]  w_col;
  logic [c_ROW_W-1:0]  r_row;
  logic [c_ROW_W-1:0]  w_row;

  logic [PIX_BITS-1:0] r_lb0 [IMG_WIDTH];
  logic [PIX_BITS-1:0] r_lb1 [IMG_WIDTH];
  // r_win[row][col]: row 0 is line y-2, row 2 is line y; col 2 is the newest pixel
  logic [PIX_BITS-1:0] r_win [3][3];

  logic                r_ctrl_en;
  logic                r_ctrl_mode;
  logic [PIX_BITS-1:0] r_thresh;
  logic                r_frm_en;
  logic                r_frm_mode;
  logic                w_frm_en;
  logic                w_frm_mode;

  logic                r_s1_valid;
  logic [c_DW-1:0]     r_s1_data;
  logic                r_s1_sop;
  logic                r_s1_eop;
  logic                r_s1_border;
  logic                r_s1_en;
  logic                r_s1_mode;

  logic [c_GW-1:0]     w_gx_p;
  logic [c_GW-1:0]     w_gx_n;
  logic [c_GW-1:0]     w_gy_p;
  logic [c_GW-1:0]     w_gy_n;
  logic [c_GW-1:0]     w_gx;
  logic [c_GW-1:0]     w_gy;
  logic [c_GW-1:0]     w_ax;
  logic [c_GW-1:0]     w_ay;
  logic [c_MW-1:0]     w_mag_sum;
  logic [PIX_BITS-1:0] w_mag;
  logic                w_hit;
  logic [c_DW-1:0]     w_out;

  logic                w_wr;
  logic                w_rd;
  logic [31:0]         w_rdata;
  logic                r_busy;
  logic                r_short;
  logic                w_short_evt;
  logic [31:0]         r_frames;
  logic [31:0]         w_edges;
  logic                w_unused;

  // ---------------------------------------------------------------- handshake
  assign w_advance  = source_ready | ~source_valid;
  assign sink_ready = r_rst_done & w_advance;
  assign w_accept   = sink_valid & sink_ready;

  assign w_col      = sink_sop ? '0 : r_col;
  assign w_row      = sink_sop ? '0 : r_row;
  assign w_frm_en   = sink_sop ? r_ctrl_en : r_frm_en;
  assign w_frm_mode = sink_sop ? (r_ctrl_mode | mode) : r_frm_mode;

  generate
    if (CHANNELS == 3) begin : g_luma_rgb
      logic [PIX_BITS+1:0] w_sum;
      assign w_sum  = {2'b00, sink_data[c_DW-1 -: PIX_BITS]}
                    + {1'b0, sink_data[2*PIX_BITS-1 -: PIX_BITS], 1'b0}
                    + {2'b00, sink_data[PIX_BITS-1:0]};
      assign w_luma = PIX_BITS'(w_sum >> 2);
    end else begin : g_luma_mono
      assign w_luma = sink_data[PIX_BITS-1:0];
    end
  endgenerate

  // --------------------------------------------------------- stage 1 / position
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_done  <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_frm_en    <= 1'b1;
      r_frm_mode  <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_sop    <= 1'b0;
      r_s1_eop    <= 1'b0;
      r_s1_border <= 1'b1;
      r_s1_en     <= 1'b0;
      r_s1_mode   <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      r_rst_done <= 1'b1;
      if (w_accept) begin
        r_frm_en   <= w_frm_en;
        r_frm_mode <= w_frm_mode;
        if (w_col == c_COL_LAST) begin
          r_col <= '0;
          r_row <= w_row + c_ROW_W'(1);
        end else begin
          r_col <= w_col + c_COL_W'(1);
          r_row <= w_row;
        end
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= r_lb1[w_col];
        r_win[1][2] <= r_lb0[w_col];
        r_win[2][2] <= w_luma;
      end
      if (w_advance) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_data   <= sink_data;
          r_s1_sop    <= sink_sop;
          r_s1_eop    <= sink_eop;
          r_s1_border <= (w_col <= c_COL_W'(1)) || (w_row <= c_ROW_W'(1));
          r_s1_en     <= w_frm_en;
          r_s1_mode   <= w_frm_mode;
        end
      end
    end
  end

  // Line buffers shift down one line per accepted beat at the current column
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb0[w_col] <= w_luma;
      r_lb1[w_col] <= r_lb0[w_col];
    end
  end

  // ------------------------------------------------------------ stage 2 / Sobel
  assign w_gx_p = c_GW'(r_win[0][2]) + (c_GW'(r_win[1][2]) << 1) + c_GW'(r_win[2][2]);
  assign w_gx_n = c_GW'(r_win[0][0]) + (c_GW'(r_win[1][0]) << 1) + c_GW'(r_win[2][0]);
  assign w_gy_p = c_GW'(r_win[2][0]) + (c_GW'(r_win[2][1]) << 1) + c_GW'(r_win[2][2]);
  assign w_gy_n = c_GW'(r_win[0][0]) + (c_GW'(r_win[0][1]) << 1) + c_GW'(r_win[0][2]);
  assign w_gx   = w_gx_p - w_gx_n;
  assign w_gy   = w_gy_p - w_gy_n;
  assign w_ax   = w_gx[c_GW-1] ? ((~w_gx) + c_GW'(1)) : w_gx;
  assign w_ay   = w_gy[c_GW-1] ? ((~w_gy) + c_GW'(1)) : w_gy;

  assign w_mag_sum = {1'b0, w_ax} + {1'b0, w_ay};
  assign w_mag     = r_s1_border ? '0 :
                     (w_mag_sum > c_MW'(c_PIX_MAX)) ? c_PIX_MAX : w_mag_sum[PIX_BITS-1:0];
  assign w_hit     = (w_mag >= r_thresh);

  always_comb begin
    w_out = r_s1_data;
    if (r_s1_en) begin
      if (r_s1_mode) begin
        w_out = w_hit ? '1 : '0;
      end else begin
        w_out = {CHANNELS{w_mag}};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      source_valid <= 1'b0;
      source_data  <= '0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
    end else if (w_advance) begin
      source_valid <= r_s1_valid;
      if (r_s1_valid) begin
        source_data <= w_out;
        source_sop  <= r_s1_sop;
        source_eop  <= r_s1_eop;
      end
    end
  end

`ifdef EEE_EDGE_COUNT_EN
  logic [31:0] r_edge_cnt;
  logic [31:0] r_edges;
  logic [31:0] w_cnt_next;

  assign w_cnt_next = (r_s1_sop ? 32'd0 : r_edge_cnt) + {31'd0, (r_s1_en & w_hit)};
  assign w_edges    = r_edges;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_cnt <= '0;
      r_edges    <= '0;
    end else if (w_advance && r_s1_valid) begin
      if (r_s1_eop) begin
        r_edges    <= w_cnt_next;
        r_edge_cnt <= '0;
      end else begin
        r_edge_cnt <= w_cnt_next;
      end
    end
  end
`else
  assign w_edges = '0;
`endif

  // ----------------------------------------------------------- control/status
  assign w_wr = s_chipselect & s_write;
  assign w_rd = s_chipselect & s_read;

  // A restarting sop only flags a short line if the previous line was partial
  assign w_short_evt = w_accept &
                       ((sink_sop & r_busy & (r_col != '0)) |
                        (sink_eop & (w_col != c_COL_LAST)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl_en   <= 1'b1;
      r_ctrl_mode <= 1'b0;
      r_thresh    <= c_THRESH_RST;
      r_busy      <= 1'b0;
      r_short     <= 1'b0;
      r_frames    <= '0;
      s_readdata  <= '0;
    end else begin
      if (w_wr && (s_address == c_A_CTRL)) begin
        r_ctrl_en   <= s_writedata[0];
        r_ctrl_mode <= s_writedata[1];
      end
      if (w_wr && (s_address == c_A_THRESH)) begin
        r_thresh <= s_writedata[PIX_BITS-1:0];
      end
      if (w_short_evt) begin
        r_short <= 1'b1;
      end else if (w_wr && (s_address == c_A_STATUS) && s_writedata[1]) begin
        r_short <= 1'b0;
      end
      if (w_accept) begin
        if (sink_eop) begin
          r_busy   <= 1'b0;
          r_frames <= r_frames + 32'd1;
        end else if (sink_sop) begin
          r_busy <= 1'b1;
        end
      end
      if (w_rd) begin
        s_readdata <= w_rdata;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (s_address)
      c_A_CTRL:   w_rdata = {30'd0, r_ctrl_mode, r_ctrl_en};
      c_A_THRESH: w_rdata = 32'(r_thresh);
      c_A_STATUS: w_rdata = {30'd0, r_short, r_busy};
      c_A_FRAMES: w_rdata = r_frames;
      c_A_EDGES:  w_rdata = w_edges;
      c_A_ID:     w_rdata = c_ID;
      default:    w_rdata = '0;
    endcase
  end

  assign w_unused = &{1'b0, s_writedata};

endmodule
`default_nettype wire

// File: tb/tb_eee_sobel_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_eee_sobel_stream
// Purpose  : Scoreboard bench for eee_sobel_stream (8-bit RGB, 8-pixel lines).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eee_sobel_stream;

  localparam int c_W = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] sink_data = '0;
  logic        sink_valid = 1'b0;
  logic        sink_ready;
  logic        sink_sop = 1'b0;
  logic        sink_eop = 1'b0;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready = 1'b1;
  logic        source_sop;
  logic        source_eop;
  logic        s_chipselect = 1'b0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [2:0]  s_address = '0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        mode_pin = 1'b0;

  eee_sobel_stream #(
    .PIX_BITS(8), .CHANNELS(3), .IMG_WIDTH(c_W), .THRESH_RST(64)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop),
    .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .mode(mode_pin)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic        sop;
    logic        eop;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   bp_en = 1'b0;
  bit   lat_chk = 1'b0;

  // Bench-side configuration and reference-model state
  bit cfg_en = 1'b1;
  bit cfg_mode = 1'b0;
  int cfg_thr = 64;
  int m_col = 0, m_row = 0;
  bit m_en = 1'b1, m_mode = 1'b0;
  int m_cnt = 0, m_edges = 0, m_frames = 0;
  int lum [16][c_W];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    source_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Reference: Sobel over the 2-D luma image, gradient centred one pixel up-left
  function automatic logic [23:0] model_beat(input logic [23:0] d, input logic sop,
                                             input logic eop);
    int x, y, mag, gx, gy, p, wx, wy;
    bit hit;
    logic [23:0] res;
    logic [7:0] m8;
    if (sop) begin
      m_col = 0; m_row = 0;
      m_en = cfg_en; m_mode = cfg_mode | mode_pin;
      m_cnt = 0;
    end
    x = m_col; y = m_row;
    lum[y % 16][x] = (int'(d[23:16]) + 2 * int'(d[15:8]) + int'(d[7:0])) / 4;
    mag = 0;
    if (x >= 2 && y >= 2) begin
      gx = 0; gy = 0;
      for (int dy = 0; dy < 3; dy++) begin
        for (int dx = 0; dx < 3; dx++) begin
          p  = lum[(y - 2 + dy) % 16][x - 2 + dx];
          wx = (dx - 1) * ((dy == 1) ? 2 : 1);
          wy = (dy - 1) * ((dx == 1) ? 2 : 1);
          gx += wx * p;
          gy += wy * p;
        end
      end
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (mag > 255) mag = 255;
    end
    hit = (mag >= cfg_thr);
    if (m_en && hit) m_cnt++;
    m8 = 8'(mag);
    if (!m_en)       res = d;
    else if (m_mode) res = hit ? 24'hFFFFFF : 24'h000000;
    else             res = {m8, m8, m8};
    if (eop) begin
      m_frames++;
      m_edges = m_cnt;
      m_cnt = 0;
    end
    if (x == c_W - 1) begin
      m_col = 0; m_row = m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
    return res;
  endfunction

  task automatic send(input logic [23:0] d, input logic sop, input logic eop);
    int guard;
    exp_t e;
    guard = 0;
    sink_data = d; sink_sop = sop; sink_eop = eop; sink_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (sink_ready) break;
      guard++;
      if (guard > 1000) begin
        checks++; failures++;
        $display("FAIL sink_ready_timeout actual=0 required=1");
        finish_now();
      end
    end
    e.data = model_beat(d, sop, eop);
    e.sop = sop; e.eop = eop; e.cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
  endtask

  function automatic logic [23:0] gen_pix(input int kind, input int x);
    if (kind == 0) return 24'h404040;
    if (kind == 1) return (x < 4) ? 24'h000000 : 24'hFFFFFF;
    return 24'($urandom());
  endfunction

  task automatic send_frame(input int kind, input int rows, input bit gaps);
    for (int i = 0; i < rows * c_W; i++) begin
      send(gen_pix(kind, i % c_W), i == 0, i == rows * c_W - 1);
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        checks++; failures++;
        $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        finish_now();
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic mm_write(input logic [2:0] a, input logic [31:0] d);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    @(posedge clk);
    #1;
    s_chipselect = 1'b0; s_write = 1'b0;
  endtask

  task automatic mm_read(input logic [2:0] a, input logic [31:0] expv, input string name);
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    @(posedge clk);
    #1;
    s_chipselect = 1'b0; s_read = 1'b0;
    checks++;
    if (s_readdata !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, s_readdata, expv);
    end
  endtask

  task automatic check_edges();
`ifdef EEE_EDGE_COUNT_EN
    mm_read(3'd4, 32'(m_edges), "edges");
`else
    mm_read(3'd4, 32'd0, "edges");
`endif
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes an output beat
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset_n && source_valid && source_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat actual=%h required=none", source_data);
      end else begin
        e = exp_q.pop_front();
        if ({source_data, source_sop, source_eop} !== {e.data, e.sop, e.eop}) begin
          failures++;
          $display("FAIL beat actual=%h/%b/%b required=%h/%b/%b", source_data,
                   source_sop, source_eop, e.data, e.sop, e.eop);
        end
        if (lat_chk) begin
          checks++;
          if (cyc - e.cyc != 2) begin
            failures++;
            $display("FAIL latency actual=%0d required=2", cyc - e.cyc);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checks++;
    if ({sink_ready, source_valid, source_sop, source_eop} !== 4'b0000 || s_readdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs actual=%b/%h required=0000/0",
               {sink_ready, source_valid, source_sop, source_eop}, s_readdata);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    mm_read(3'd0, 32'h1, "ctrl_reset");
    mm_read(3'd1, 32'd64, "thresh_reset");
    mm_read(3'd2, 32'h0, "status_reset");
    mm_read(3'd3, 32'h0, "frames_reset");
    mm_read(3'd4, 32'h0, "edges_reset");
    mm_read(3'd5, 32'h5E0B0001, "id");
    mm_read(3'd6, 32'h0, "addr6");

    // Flat grey, magnitude output, no stalls: latency checked per beat
    lat_chk = 1'b1;
    send_frame(0, 4, 1'b0);
    drain();
    lat_chk = 1'b0;

    // Vertical step, threshold output
    mm_write(3'd0, 32'h3); cfg_mode = 1'b1;
    send_frame(1, 4, 1'b0);
    drain();
    check_edges();

    // Same step, magnitude output, then via the mode pin
    mm_write(3'd0, 32'h1); cfg_mode = 1'b0;
    send_frame(1, 4, 1'b0);
    drain();
    mode_pin = 1'b1;
    send_frame(1, 4, 1'b0);
    drain();
    mode_pin = 1'b0;
    check_edges();

    // Random images, random threshold, backpressure and input gaps
    bp_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      cfg_thr = $urandom_range(0, 255);
      mm_write(3'd1, 32'(cfg_thr));
      cfg_mode = f[0];
      mm_write(3'd0, {30'd0, cfg_mode, 1'b1});
      send_frame(2, 3 + f, 1'b1);
      drain();
      check_edges();
    end

    // Bypass with backpressure
    mm_write(3'd0, 32'h0); cfg_en = 1'b0; cfg_mode = 1'b0;
    for (int f = 0; f < 2; f++) begin
      send_frame(2, 4, 1'b1);
      drain();
      mm_read(3'd3, 32'(m_frames), "frames_bypass");
    end
    bp_en = 1'b0;

    // sop injected at column 3 of row 1
    mm_write(3'd0, 32'h1); cfg_en = 1'b1;
    for (int i = 0; i < c_W + 3; i++) send(24'($urandom()), i == 0, 1'b0);
    for (int i = 0; i < 5; i++) send(24'($urandom()), i == 0, 1'b0);
    drain();
    mm_read(3'd2, 32'h3, "status_mid_frame");
    for (int i = 5; i < 4 * c_W; i++) send(24'($urandom()), 1'b0, i == 4 * c_W - 1);
    drain();
    mm_read(3'd2, 32'h2, "status_short");
    mm_write(3'd2, 32'h2);
    mm_read(3'd2, 32'h0, "status_cleared");
    mm_write(3'd7, 32'hFFFF_FFFF);
    mm_read(3'd7, 32'h0, "addr7");
    mm_read(3'd5, 32'h5E0B0001, "id_again");
    mm_read(3'd3, 32'(m_frames), "frames_final");
    check_edges();

    finish_now();
  end

  initial begin
    #2000000;
    checks++; failures++;
    $display("FAIL global_timeout actual=running required=finished");
    finish_now();
  end

endmodule
`default_nettype wire
